// File: rtl/hub75_bcm_scheduler.sv
// HUB75 panel scan scheduler with binary-coded modulation.
// Shifts one bit-plane per row, latches it, then holds OE for a plane-weighted time.
module hub75_bcm_scheduler #(
  parameter int SCREEN_WIDTH = 32,
  parameter int SCREEN_DEPTH = 16,
  parameter int COLOR_BITS   = 4,
  parameter int BASE_ON      = SCREEN_WIDTH + 1
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    locked,
  input  logic                    swap_req,
  output logic                    rd_en,
  output logic [$clog2(SCREEN_DEPTH)+$clog2(SCREEN_WIDTH):0] rd_addr,
  input  logic [6*COLOR_BITS-1:0] rd_data,
  output logic                    R1_data,
  output logic                    G1_data,
  output logic                    B1_data,
  output logic                    R2_data,
  output logic                    G2_data,
  output logic                    B2_data,
  output logic                    A,
  output logic                    B,
  output logic                    C,
  output logic                    D,
  output logic                    E,
  output logic                    clk_out,
  output logic                    LAT,
  output logic                    OE_N,
  output logic                    buf_sel,
  output logic                    swap_ack,
  output logic                    frame_done
);

  localparam int CW = $clog2(SCREEN_WIDTH);
  localparam int RW = $clog2(SCREEN_DEPTH);
  localparam int PW = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int AW = 1 + RW + CW;
  localparam int ON_MAX = BASE_ON << (COLOR_BITS - 1);
  localparam int SH_MAX = 2 * SCREEN_WIDTH + 2;
  localparam int CNT_W = $clog2(((ON_MAX > SH_MAX) ? ON_MAX : SH_MAX) + 1);

  localparam logic [CNT_W-1:0] SH_END   = CNT_W'(2 * SCREEN_WIDTH + 1);
  localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(2 * SCREEN_WIDTH);
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(2 * SCREEN_WIDTH - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(2 * SCREEN_WIDTH - 2);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PW-1:0]    P_LAST   = PW'(COLOR_BITS - 1);
  localparam logic [RW-1:0]    R_LAST   = RW'(SCREEN_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    DISPLAY
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PW-1:0]    plane_q, plane_d;
  logic             rd_en_q, rd_en_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [5:0]       pix_q, pix_d;
  logic [4:0]       addr_q, addr_d;
  logic             clk_out_q, clk_out_d;
  logic             lat_q, lat_d;
  logic             oe_n_q, oe_n_d;
  logic             buf_sel_q, buf_sel_d;
  logic             pend_q, pend_d;
  logic             swap_ack_q, swap_ack_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] tn;
  logic [CNT_W-1:0] on_last;

  // Next-state and next-output computation for the scan sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    plane_d      = plane_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    pix_d        = pix_q;
    addr_d       = addr_q;
    clk_out_d    = 1'b0;
    lat_d        = 1'b0;
    oe_n_d       = 1'b1;
    buf_sel_d    = buf_sel_q;
    swap_ack_d   = 1'b0;
    frame_done_d = 1'b0;
    pend_d       = pend_q | swap_req;
    tn           = cnt_q + CNT_ONE;
    on_last      = (CNT_W'(BASE_ON) << plane_q) - CNT_ONE;
    if (!locked) begin
      state_d = IDLE;
      cnt_d   = '0;
      row_d   = '0;
      plane_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = SHIFT;
          cnt_d     = '0;
          rd_en_d   = 1'b1;
          rd_addr_d = {buf_sel_q, row_q, CW'(0)};
        end
        SHIFT: begin
          cnt_d = tn;
          if (!cnt_q[0] && cnt_q >= CNT_TWO && cnt_q <= CLK_LAST)
            clk_out_d = 1'b1;
          if (cnt_q[0] && cnt_q <= PIX_LAST) begin
            for (int ch = 0; ch < 6; ch++)
              pix_d[ch] = rd_data[ch*COLOR_BITS + int'(plane_q)];
          end
          if (!tn[0] && tn <= RD_LAST) begin
            rd_en_d   = 1'b1;
            rd_addr_d = {buf_sel_q, row_q, tn[CW:1]};
          end
          if (cnt_q == SH_END) begin
            state_d = LATCH;
            cnt_d   = '0;
            lat_d   = 1'b1;
            addr_d  = 5'(row_q);
          end
        end
        LATCH: begin
          state_d = DISPLAY;
          cnt_d   = '0;
          oe_n_d  = 1'b0;
        end
        DISPLAY: begin
          if (cnt_q == on_last) begin
            state_d = SHIFT;
            cnt_d   = '0;
            rd_en_d = 1'b1;
            if (plane_q != P_LAST) begin
              plane_d = plane_q + PW'(1);
            end else begin
              plane_d = '0;
              if (row_q == R_LAST) begin
                row_d        = '0;
                frame_done_d = 1'b1;
                if (pend_q) begin
                  buf_sel_d  = ~buf_sel_q;
                  swap_ack_d = 1'b1;
                  pend_d     = 1'b0;
                end
              end else begin
                row_d = row_q + RW'(1);
              end
            end
            rd_addr_d = {buf_sel_d, row_d, CW'(0)};
          end else begin
            cnt_d  = cnt_q + CNT_ONE;
            oe_n_d = 1'b0;
          end
        end
      endcase
    end
  end

  // State and registered outputs; reset drives the panel dark.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      pix_q        <= '0;
      addr_q       <= '0;
      clk_out_q    <= 1'b0;
      lat_q        <= 1'b0;
      oe_n_q       <= 1'b1;
      buf_sel_q    <= 1'b0;
      pend_q       <= 1'b0;
      swap_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      pix_q        <= pix_d;
      addr_q       <= addr_d;
      clk_out_q    <= clk_out_d;
      lat_q        <= lat_d;
      oe_n_q       <= oe_n_d;
      buf_sel_q    <= buf_sel_d;
      pend_q       <= pend_d;
      swap_ack_q   <= swap_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign R1_data    = pix_q[0];
  assign G1_data    = pix_q[1];
  assign B1_data    = pix_q[2];
  assign R2_data    = pix_q[3];
  assign G2_data    = pix_q[4];
  assign B2_data    = pix_q[5];
  assign A          = addr_q[0];
  assign B          = addr_q[1];
  assign C          = addr_q[2];
  assign D          = addr_q[3];
  assign E          = addr_q[4];
  assign clk_out    = clk_out_q;
  assign LAT        = lat_q;
  assign OE_N       = oe_n_q;
  assign buf_sel    = buf_sel_q;
  assign swap_ack   = swap_ack_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/hub75_bcm_scheduler.md
# hub75_bcm_scheduler

Sequences a HUB75-style LED matrix panel with binary-coded-modulation (BCM) brightness: it reads pixel words from a double-buffered frame RAM, shifts one bit-plane per row into the panel, latches it, and holds the outputs enabled for a plane-weighted on-time. It sits between the frame-buffer RAM (synchronous read port, 1-cycle latency) and the panel pins. It replaces fixed test-pattern generation with a real scan schedule and a safe frame-boundary buffer swap.

## Interface
- SCREEN_WIDTH, 32, columns per row; power of 2, ≥4
- SCREEN_DEPTH, 16, scan rows (upper and lower half share an address); power of 2, ≤32
- COLOR_BITS, 4, bits per color channel (BCM planes), 1..8
- BASE_ON, SCREEN_WIDTH+1, OE-active cycles for plane 0; plane p gets BASE_ON<<p
- clk_in  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- locked  in  1  run enable (PLL lock); low forces IDLE
- swap_req  in  1  level request to flip display buffer; hold until swap_ack
- rd_en  out  1  frame RAM read strobe
- rd_addr  out  1+log2(DEPTH)+log2(WIDTH)  {buf_sel, row, column}
- rd_data  in  6*COLOR_BITS  {B2,G2,R2,B1,G1,R1}, R1 in LSBs; valid the cycle after rd_en
- R1_data, G1_data, B1_data, R2_data, G2_data, B2_data  out  1 each  registered serial pixel bits
- A, B, C, D, E  out  1 each  row address {E,D,C,B,A} = row, zero-extended
- clk_out  out  1  registered panel shift clock
- LAT  out  1  latch strobe
- OE_N  out  1  output enable, active low
- buf_sel  out  1  buffer currently displayed
- swap_ack  out  1  one-cycle pulse when buf_sel toggles
- frame_done  out  1  one-cycle pulse at end of each frame

## Operation
- States: IDLE, SHIFT, LATCH, DISPLAY. Counters: column, row, plane, on-time.
- IDLE: OE_N=1; row=plane=column=0. First edge with locked=1 enters SHIFT.
- SHIFT (2·WIDTH+2 cycles, local cycle t=0..): in cycle 2k, rd_en=1, rd_addr={buf_sel,row,k}; at end of cycle 2k+1, bit `plane` of each channel of rd_data is registered onto R1..B2; clk_out=1 only in cycle 2k+3. OE_N=1, LAT=0.
- LATCH (1 cycle): LAT=1, OE_N=1; A..E updated to row at entry.
- DISPLAY: OE_N=0 for exactly BASE_ON<<plane cycles; then: plane<COLOR_BITS-1 → plane+1, same row; else plane=0 and row+1.
- Row wrap (row=SCREEN_DEPTH-1, last plane done): row=0, frame_done pulse; if swap pending, toggle buf_sel and pulse swap_ack in the same cycle. Then SHIFT.
- swap_req sampled every cycle into a pending flag; cleared with swap_ack. Request asserted in the frame_done cycle itself applies at the next frame end.
- locked deasserted in any state: next edge → IDLE, OE_N=1, LAT=0, clk_out=0, rd_en=0; frame restarts at row 0, plane 0. buf_sel and pending flag kept.
- On-time counter is wide enough for BASE_ON<<(COLOR_BITS-1); no wrap.

## Timing
- Reset values: OE_N=1; all other outputs 0; buf_sel=0; state IDLE.
- All outputs registered except rd_addr and rd_en, which are also registered (no combinational path from inputs).
- RAM read latency exactly 1 cycle.
- Data for column k stable on R1..B2 in cycles 2k+2 and 2k+3; clk_out rises at start of 2k+3 (one-cycle setup, one-cycle hold).
- Cycles per row-plane = 2·WIDTH+3+BASE_ON·2^plane. Defaults: 763 per row, 12208 per frame.
- OE_N never low while LAT=1 or clk_out=1.
- rst_n assertion mid-frame: all outputs return to reset values immediately (asynchronously).

## Test plan
- Reset, locked=1, RAM all zero: first rd_en at cycle 1 after locked, addr 0; LAT pulse at cycle 66 of SHIFT/LATCH sequence; OE_N low 33 cycles.
- RAM word col 3 row 0 = R1 value 4'b0101: R1_data=1 during planes 0 and 2, 0 during planes 1 and 3, only at clk_out edge #4.
- Count one frame at defaults: frame_done period 12208 cycles; OE_N low lengths 33/66/132/264 repeating; A..E steps 0..15.
- swap_req pulse mid-frame held until ack: swap_ack coincides with next frame_done; subsequent rd_addr MSB=1.
- Deassert locked during DISPLAY of row 5: next cycle OE_N=1, state IDLE; on re-lock first rd_addr = {buf_sel,0,0}.
- Assertion check over random run: OE_N low never overlaps LAT or clk_out; rd_en never outside SHIFT.
